// File: rtl/regfile_ctx_if.sv
// Register-file bus: read ports, write port and context (irq/iret) handshake.
interface regfile_ctx_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 4,
    parameter int FLAG_W = 2
);
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic [DATA_W-1:0] rd1;
    logic [DATA_W-1:0] rd2;
    logic              wr_en;
    logic [1:0]        wr_mode;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              irq_req;
    logic [DATA_W-1:0] irq_pc;
    logic [FLAG_W-1:0] irq_flags;
    logic              iret_req;
    logic [FLAG_W-1:0] flag_out;
    logic              irq_ack;
    logic              iret_ack;
    logic              ctx_busy;

    modport master (
        output rs1, rs2, wr_en, wr_mode, wr_addr, wr_data,
               irq_req, irq_pc, irq_flags, iret_req,
        input  rd1, rd2, flag_out, irq_ack, iret_ack, ctx_busy
    );

    modport slave (
        input  rs1, rs2, wr_en, wr_mode, wr_addr, wr_data,
               irq_req, irq_pc, irq_flags, iret_req,
        output rd1, rd2, flag_out, irq_ack, iret_ack, ctx_busy
    );
endinterface

// File: rtl/regfile_ctx.sv
// Register file with write/set/clear port, write-to-read bypass and an
// interrupt context unit that saves PC/flags and restores flags.

// One read port: array lookup with bypass of the pending port write.
module regfile_rdport #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = 4
) (
    input  logic [NUM_REGS-1:0][DATA_W-1:0] regs,
    input  logic [ADDR_W-1:0]               rs,
    input  logic                            wr_act,
    input  logic [ADDR_W-1:0]               wr_addr,
    input  logic [DATA_W-1:0]               wr_nxt,
    output logic [DATA_W-1:0]               rd
);
    assign rd = (wr_act && wr_addr == rs) ? wr_nxt : regs[rs];
endmodule

module regfile_ctx #(
    parameter int DATA_W   = 32,
    parameter int NUM_REGS = 16,
    parameter int ADDR_W   = $clog2(NUM_REGS),
    parameter int FLAG_W   = 2,
    parameter int EPC_IDX  = 12,
    parameter int EFL_IDX  = 13
) (
    input logic         clk,
    input logic         rst_n,
    regfile_ctx_if.slave bus
);
    localparam int NUM_RP = 2;

    typedef enum logic [1:0] {IDLE, SAVE_PC, SAVE_FL, RESTORE} state_t;

    state_t                          state;
    logic [NUM_REGS-1:0][DATA_W-1:0] regs;
    logic [DATA_W-1:0]               pc_q;
    logic [FLAG_W-1:0]               fl_q;

    logic                            wr_act;
    logic [DATA_W-1:0]               wr_nxt;
    logic                            ctx_we;
    logic [ADDR_W-1:0]               ctx_addr;
    logic [DATA_W-1:0]               ctx_data;
    logic [NUM_RP-1:0][ADDR_W-1:0]   rs_v;
    logic [NUM_RP-1:0][DATA_W-1:0]   rd_v;

    assign wr_act = bus.wr_en && (bus.wr_mode != 2'b11);

    // Next value of the addressed register under the current write mode.
    always_comb begin
        case (bus.wr_mode)
            2'b01:   wr_nxt = regs[bus.wr_addr] | bus.wr_data;
            2'b10:   wr_nxt = regs[bus.wr_addr] & bus.wr_data;
            default: wr_nxt = bus.wr_data;
        endcase
    end

    // Context-unit write is a pure function of the save states.
    always_comb begin
        ctx_we   = (state == SAVE_PC) || (state == SAVE_FL);
        ctx_addr = (state == SAVE_PC) ? ADDR_W'(EPC_IDX) : ADDR_W'(EFL_IDX);
        ctx_data = (state == SAVE_PC) ? pc_q : DATA_W'(fl_q);
    end

    // Register array; the context write is applied last so it wins a collision.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs <= '0;
        end else begin
            if (wr_act) regs[bus.wr_addr] <= wr_nxt;
            if (ctx_we) regs[ctx_addr]    <= ctx_data;
        end
    end

    assign rs_v = {bus.rs2, bus.rs1};

    for (genvar p = 0; p < NUM_RP; p++) begin : g_rp
        regfile_rdport #(
            .DATA_W  (DATA_W),
            .NUM_REGS(NUM_REGS),
            .ADDR_W  (ADDR_W)
        ) u_rdport (
            .regs   (regs),
            .rs     (rs_v[p]),
            .wr_act (wr_act),
            .wr_addr(bus.wr_addr),
            .wr_nxt (wr_nxt),
            .rd     (rd_v[p])
        );
    end

    assign bus.rd1 = rd_v[0];
    assign bus.rd2 = rd_v[1];

    // Context FSM with registered ack/busy/flag outputs; irq beats iret in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            pc_q         <= '0;
            fl_q         <= '0;
            bus.flag_out <= '0;
            bus.irq_ack  <= 1'b0;
            bus.iret_ack <= 1'b0;
            bus.ctx_busy <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.irq_req) begin
                        pc_q         <= bus.irq_pc;
                        fl_q         <= bus.irq_flags;
                        state        <= SAVE_PC;
                        bus.ctx_busy <= 1'b1;
                    end else if (bus.iret_req) begin
                        state        <= RESTORE;
                        bus.ctx_busy <= 1'b1;
                        bus.iret_ack <= 1'b1;
                    end
                end
                SAVE_PC: begin
                    state       <= SAVE_FL;
                    bus.irq_ack <= 1'b1;
                end
                SAVE_FL: begin
                    state        <= IDLE;
                    bus.irq_ack  <= 1'b0;
                    bus.ctx_busy <= 1'b0;
                end
                default: begin
                    state        <= IDLE;
                    bus.flag_out <= regs[EFL_IDX][FLAG_W-1:0];
                    bus.iret_ack <= 1'b0;
                    bus.ctx_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_ctx.sv
// Self-checking bench for regfile_ctx: random port traffic against an array
// model plus directed interrupt save/restore timelines.
module tb_regfile_ctx;
    localparam int DW = 32;
    localparam int NR = 16;
    localparam int AW = 4;
    localparam int FW = 2;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    regfile_ctx_if #(.DATA_W(DW), .ADDR_W(AW), .FLAG_W(FW)) bus ();

    regfile_ctx #(
        .DATA_W(DW), .NUM_REGS(NR), .FLAG_W(FW), .EPC_IDX(12), .EFL_IDX(13)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    int errs = 0;
    int checks = 0;
    logic [DW-1:0] mdl [NR];
    logic [FW-1:0] mdl_flag;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.wr_en = 0; bus.wr_mode = 0; bus.wr_addr = 0; bus.wr_data = 0;
        bus.irq_req = 0; bus.irq_pc = 0; bus.irq_flags = 0; bus.iret_req = 0;
        bus.rs1 = 0; bus.rs2 = 0;
    endtask

    function automatic logic [DW-1:0] apply(logic [DW-1:0] old, logic [1:0] m, logic [DW-1:0] d);
        if (m == 2'b00) return d;
        if (m == 2'b01) return old | d;
        if (m == 2'b10) return old & d;
        return old;
    endfunction

    task automatic test_reset();
        idle_inputs();
        rst_n = 0;
        step(); step();
        rst_n = 1;
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        mdl_flag = '0;
        step();
        checks++;
        if ({bus.irq_ack, bus.iret_ack, bus.ctx_busy} !== 3'b000) begin
            errs++; $display("FAIL reset_ctl: got %b want 000", {bus.irq_ack, bus.iret_ack, bus.ctx_busy});
        end
        checks++;
        if (bus.flag_out !== 2'b00) begin
            errs++; $display("FAIL reset_flag: got %b want 00", bus.flag_out);
        end
        for (int i = 0; i < NR; i++) begin
            bus.rs1 = AW'(i); bus.rs2 = AW'(NR-1-i);
            #1;
            checks++;
            if (bus.rd1 !== 0 || bus.rd2 !== 0) begin
                errs++; $display("FAIL reset_reg%0d: got %h/%h want 0", i, bus.rd1, bus.rd2);
            end
        end
    endtask

    task automatic test_plain_write();
        bus.wr_en = 1; bus.wr_mode = 2'b00; bus.wr_addr = 3; bus.wr_data = 32'h5A;
        bus.rs1 = 3; bus.rs2 = 3;
        #1;
        checks++;
        if (bus.rd1 !== 32'h5A || bus.rd2 !== 32'h5A) begin
            errs++; $display("FAIL plain_bypass: got %h/%h want 5a", bus.rd1, bus.rd2);
        end
        step();
        mdl[3] = 32'h5A;
        bus.wr_en = 0;
        for (int i = 0; i < NR; i++) begin
            bus.rs1 = AW'(i);
            #1;
            checks++;
            if (bus.rd1 !== mdl[i]) begin
                errs++; $display("FAIL plain_array r%0d: got %h want %h", i, bus.rd1, mdl[i]);
            end
        end
    endtask

    task automatic test_set_clear();
        logic [DW-1:0] want [3] = '{32'hFF, 32'h3C, 32'h3C};
        logic [1:0]    mode [3] = '{2'b01, 2'b10, 2'b11};
        logic [DW-1:0] dat  [3] = '{32'h0F, 32'h3C, 32'hFFFF_0000};
        bus.wr_en = 1; bus.wr_mode = 2'b00; bus.wr_addr = 4; bus.wr_data = 32'hF0;
        step();
        bus.rs1 = 4; bus.rs2 = 4;
        for (int k = 0; k < 3; k++) begin
            bus.wr_en = 1; bus.wr_mode = mode[k]; bus.wr_addr = 4; bus.wr_data = dat[k];
            #1;
            checks++;
            if (bus.rd1 !== want[k]) begin
                errs++; $display("FAIL setclr_bypass%0d: got %h want %h", k, bus.rd1, want[k]);
            end
            step();
            bus.wr_en = 0;
            #1;
            checks++;
            if (bus.rd2 !== want[k]) begin
                errs++; $display("FAIL setclr_array%0d: got %h want %h", k, bus.rd2, want[k]);
            end
        end
        mdl[4] = 32'h3C;
    endtask

    task automatic test_random_writes();
        logic [DW-1:0] nxt, e1, e2;
        for (int n = 0; n < 300; n++) begin
            bus.wr_en = 1'($urandom_range(0, 3) != 0);
            bus.wr_mode = 2'($urandom);
            bus.wr_addr = AW'($urandom);
            bus.wr_data = $urandom;
            bus.rs1 = AW'($urandom); bus.rs2 = (n % 4 == 0) ? bus.wr_addr : AW'($urandom);
            #1;
            nxt = apply(mdl[bus.wr_addr], bus.wr_mode, bus.wr_data);
            e1 = mdl[bus.rs1]; e2 = mdl[bus.rs2];
            if (bus.wr_en && bus.wr_mode != 2'b11) begin
                if (bus.wr_addr == bus.rs1) e1 = nxt;
                if (bus.wr_addr == bus.rs2) e2 = nxt;
            end
            checks++;
            if (bus.rd1 !== e1 || bus.rd2 !== e2) begin
                errs++; $display("FAIL rand_rd n=%0d: got %h/%h want %h/%h", n, bus.rd1, bus.rd2, e1, e2);
            end
            step();
            if (bus.wr_en) mdl[bus.wr_addr] = nxt;
        end
        bus.wr_en = 0;
    endtask

    task automatic test_irq_save();
        bus.wr_en = 0; bus.rs1 = 12; bus.rs2 = 13;
        bus.irq_req = 1; bus.irq_pc = 32'h100; bus.irq_flags = 2'b10;
        step(); // edge T
        checks++;
        if (bus.ctx_busy !== 1 || bus.irq_ack !== 0 || bus.rd1 !== mdl[12]) begin
            errs++; $display("FAIL irq_T: busy=%b ack=%b r12=%h want 1 0 %h", bus.ctx_busy, bus.irq_ack, bus.rd1, mdl[12]);
        end
        step(); // T+1
        mdl[12] = 32'h100;
        checks++;
        if (bus.ctx_busy !== 1 || bus.irq_ack !== 1 || bus.rd1 !== 32'h100 || bus.rd2 !== mdl[13]) begin
            errs++; $display("FAIL irq_T1: busy=%b ack=%b r12=%h r13=%h want 1 1 100 %h", bus.ctx_busy, bus.irq_ack, bus.rd1, bus.rd2, mdl[13]);
        end
        step(); // T+2
        bus.irq_req = 0;
        mdl[13] = 32'h2;
        checks++;
        if (bus.ctx_busy !== 0 || bus.irq_ack !== 0 || bus.rd2 !== 32'h2) begin
            errs++; $display("FAIL irq_T2: busy=%b ack=%b r13=%h want 0 0 2", bus.ctx_busy, bus.irq_ack, bus.rd2);
        end
        step();
        checks++;
        if (bus.ctx_busy !== 0 || bus.irq_ack !== 0) begin
            errs++; $display("FAIL irq_rearm: busy=%b ack=%b want 0 0", bus.ctx_busy, bus.irq_ack);
        end
    endtask

    task automatic test_iret();
        bus.iret_req = 1;
        step(); // edge T
        bus.iret_req = 0;
        checks++;
        if (bus.iret_ack !== 1 || bus.ctx_busy !== 1 || bus.flag_out !== mdl_flag) begin
            errs++; $display("FAIL iret_T: ack=%b busy=%b flag=%b want 1 1 %b", bus.iret_ack, bus.ctx_busy, bus.flag_out, mdl_flag);
        end
        step(); // T+1
        mdl_flag = mdl[13][FW-1:0];
        checks++;
        if (bus.iret_ack !== 0 || bus.ctx_busy !== 0 || bus.flag_out !== mdl_flag) begin
            errs++; $display("FAIL iret_T1: ack=%b busy=%b flag=%b want 0 0 %b", bus.iret_ack, bus.ctx_busy, bus.flag_out, mdl_flag);
        end
    endtask

    task automatic test_collision();
        bus.irq_req = 1; bus.irq_pc = 32'h100; bus.irq_flags = 2'b01;
        step(); // T: now in SAVE_PC
        bus.wr_en = 1; bus.wr_mode = 2'b00; bus.wr_addr = 12; bus.wr_data = 32'hDEAD; bus.rs1 = 12;
        #1;
        checks++;
        if (bus.rd1 !== 32'hDEAD) begin
            errs++; $display("FAIL coll_bypass: got %h want dead", bus.rd1);
        end
        step(); // T+1
        bus.wr_en = 0;
        mdl[12] = 32'h100;
        #1;
        checks++;
        if (bus.rd1 !== 32'h100) begin
            errs++; $display("FAIL coll_ctx_wins: got %h want 100", bus.rd1);
        end
        step();
        bus.irq_req = 0;
        mdl[13] = 32'h1;
    endtask

    task automatic test_back_to_back();
        int waited;
        logic [DW-1:0] pc;
        logic [FW-1:0] fl;
        for (int r = 0; r < 4; r++) begin
            pc = $urandom; fl = FW'($urandom);
            bus.wr_en = 0; bus.rs1 = 12; bus.rs2 = 13;
            bus.irq_req = 1; bus.iret_req = 1; bus.irq_pc = pc; bus.irq_flags = fl;
            step();
            checks++;
            if (bus.iret_ack !== 0 || bus.ctx_busy !== 1) begin
                errs++; $display("FAIL prio_irq_first r%0d: iret_ack=%b busy=%b want 0 1", r, bus.iret_ack, bus.ctx_busy);
            end
            step();
            step();
            bus.irq_req = 0;
            mdl[12] = pc; mdl[13] = DW'(fl);
            checks++;
            if (bus.rd1 !== pc || bus.rd2 !== DW'(fl)) begin
                errs++; $display("FAIL prio_save r%0d: r12=%h r13=%h want %h %h", r, bus.rd1, bus.rd2, pc, DW'(fl));
            end
            waited = 0;
            while (bus.iret_ack !== 1 && waited < 8) begin
                step();
                waited++;
            end
            bus.iret_req = 0;
            checks++;
            if (waited != 1) begin
                errs++; $display("FAIL prio_iret_latency r%0d: got %0d cycles want 1", r, waited);
            end
            step();
            mdl_flag = fl;
            checks++;
            if (bus.flag_out !== fl || bus.ctx_busy !== 0) begin
                errs++; $display("FAIL prio_restore r%0d: flag=%b busy=%b want %b 0", r, bus.flag_out, bus.ctx_busy, fl);
            end
        end
    endtask

    task automatic test_reset_mid();
        int acks = 0;
        bus.irq_req = 1; bus.irq_pc = 32'hCAFE; bus.irq_flags = 2'b11;
        step(); // SAVE_PC
        rst_n = 0;
        #1;
        checks++;
        if (bus.ctx_busy !== 0 || bus.irq_ack !== 0 || bus.flag_out !== 0) begin
            errs++; $display("FAIL rstmid_async: busy=%b ack=%b flag=%b want 0 0 0", bus.ctx_busy, bus.irq_ack, bus.flag_out);
        end
        bus.irq_req = 0;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.irq_ack === 1) acks++;
        end
        rst_n = 1;
        for (int i = 0; i < 3; i++) begin
            step();
            if (bus.irq_ack === 1 || bus.ctx_busy === 1) acks++;
        end
        checks++;
        if (acks != 0) begin
            errs++; $display("FAIL rstmid_noack: got %0d active cycles want 0", acks);
        end
        for (int i = 0; i < NR; i++) mdl[i] = '0;
        bus.rs1 = 12; bus.rs2 = 13;
        #1;
        checks++;
        if (bus.rd1 !== 0 || bus.rd2 !== 0 || bus.flag_out !== 0) begin
            errs++; $display("FAIL rstmid_clear: r12=%h r13=%h flag=%b want 0 0 0", bus.rd1, bus.rd2, bus.flag_out);
        end
    endtask

    initial begin
        test_reset();
        test_plain_write();
        test_set_clear();
        test_random_writes();
        test_irq_save();
        test_iret();
        test_collision();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
